// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with memory through mem_ready and flags illegal opcodes and memory timeouts.
module multicycle_ctrl #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                err,
    output logic [1:0]          err_code
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] ADDR   = 3'd4;
    localparam logic [2:0] MEM    = 3'd5;
    localparam logic [2:0] WB     = 3'd6;
    localparam logic [2:0] ERROR  = 3'd7;

    localparam logic [1:0] EC_NONE    = 2'b00;
    localparam logic [1:0] EC_ILLEGAL = 2'b01;
    localparam logic [1:0] EC_TIMEOUT = 2'b10;

    localparam int              CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic            TO_EN   = (TIMEOUT != 0);

    logic [2:0]          state;
    logic [2:0]          next_state;
    logic [OPCODE_W-1:0] opcode_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic [1:0]          err_code_q;
    logic [1:0]          next_err_code;
    logic                timeout_hit;
    logic                is_load_q;
    logic [2:0]          retire_state;

    // Legal opcodes are 0..6 with every bit above [3:0] clear.
    function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
        return (op <= OPCODE_W'(4'd6));
    endfunction

    function automatic logic op_is_nop(input logic [OPCODE_W-1:0] op);
        return (op == {OPCODE_W{1'b0}});
    endfunction

    function automatic logic op_is_mem(input logic [OPCODE_W-1:0] op);
        return (op == OPCODE_W'(4'd5)) || (op == OPCODE_W'(4'd6));
    endfunction

    // ALU code for register-register ops; ADD is also the address-add default.
    function automatic logic [ALU_OP_W-1:0] alu_code(input logic [3:0] op);
        logic [ALU_OP_W-1:0] code;
        case (op)
            4'b0001: code = ALU_OP_W'(2'd0);
            4'b0010: code = ALU_OP_W'(2'd1);
            4'b0011: code = ALU_OP_W'(2'd2);
            4'b0100: code = ALU_OP_W'(2'd3);
            default: code = ALU_OP_W'(2'd0);
        endcase
        return code;
    endfunction

    assign is_load_q    = (opcode_q == OPCODE_W'(4'd5));
    assign retire_state = run ? FETCH : IDLE;
    // mem_ready in the same cycle beats the timeout.
    assign timeout_hit  = TO_EN && (wait_cnt == CNT_MAX) && !mem_ready;

    // Next-state and error-code selection.
    always_comb begin
        next_state    = state;
        next_err_code = err_code_q;
        case (state)
            IDLE: begin
                if (run) next_state = FETCH;
                else     next_state = IDLE;
            end
            FETCH: begin
                if (mem_ready) begin
                    next_state = DECODE;
                end else if (timeout_hit) begin
                    next_state    = ERROR;
                    next_err_code = EC_TIMEOUT;
                end else begin
                    next_state = FETCH;
                end
            end
            DECODE: begin
                if (!op_legal(opcode)) begin
                    next_state    = ERROR;
                    next_err_code = EC_ILLEGAL;
                end else if (op_is_mem(opcode)) begin
                    next_state = ADDR;
                end else if (op_is_nop(opcode)) begin
                    next_state = retire_state;
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: next_state = WB;
            ADDR: next_state = MEM;
            MEM: begin
                if (mem_ready) begin
                    if (is_load_q) next_state = WB;
                    else           next_state = retire_state;
                end else if (timeout_hit) begin
                    next_state    = ERROR;
                    next_err_code = EC_TIMEOUT;
                end else begin
                    next_state = MEM;
                end
            end
            WB: next_state = retire_state;
            ERROR: begin
                if (run) begin
                    next_state = ERROR;
                end else begin
                    next_state    = IDLE;
                    next_err_code = EC_NONE;
                end
            end
            default: begin
                next_state    = IDLE;
                next_err_code = EC_NONE;
            end
        endcase
    end

    // State, captured opcode and error code registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            opcode_q   <= {OPCODE_W{1'b0}};
            err_code_q <= EC_NONE;
        end else begin
            state      <= next_state;
            err_code_q <= next_err_code;
            if (state == DECODE) opcode_q <= opcode;
            else                 opcode_q <= opcode_q;
        end
    end

    // Memory wait counter: counts stalled FETCH/MEM cycles, saturating at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= {CNT_W{1'b0}};
        end else if ((next_state != state) || mem_ready) begin
            wait_cnt <= {CNT_W{1'b0}};
        end else if (((state == FETCH) || (state == MEM)) && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + CNT_W'(1'b1);
        end else begin
            wait_cnt <= wait_cnt;
        end
    end

    // Datapath control decode; only the handshake pulses look at mem_ready/opcode.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = {ALU_OP_W{1'b0}};
        instr_done = 1'b0;
        err        = 1'b0;
        case (state)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end else begin
                    ir_write = 1'b0;
                    pc_write = 1'b0;
                end
            end
            DECODE: begin
                if (op_is_nop(opcode)) instr_done = 1'b1;
                else                   instr_done = 1'b0;
            end
            EXEC: begin
                alu_op  = alu_code(opcode_q[3:0]);
                alu_src = 1'b0;
            end
            ADDR: begin
                alu_src = 1'b1;
            end
            MEM: begin
                alu_src = 1'b1;
                if (is_load_q) mem_read = 1'b1;
                else           mem_write = 1'b1;
                if (mem_ready && !is_load_q) instr_done = 1'b1;
                else                         instr_done = 1'b0;
            end
            WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                if (is_load_q) mem_to_reg = 1'b1;
                else           alu_op     = alu_code(opcode_q[3:0]);
            end
            ERROR: begin
                err = 1'b1;
            end
            default: begin
                err = 1'b0;
            end
        endcase
    end

    assign err_code = err_code_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (default parameters).
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       pc_write, ir_write, reg_write, mem_to_reg, mem_read, mem_write, alu_src;
    logic [1:0] alu_op;
    logic       instr_done, err;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.OPCODE_W(4), .ALU_OP_W(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .alu_op(alu_op), .instr_done(instr_done),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Expected output vector: {pc,ir,rw,m2r,mr,mw,src,alu_op[1:0],done,err,err_code[1:0]}
    function automatic logic [12:0] ov(input logic pc, input logic ir, input logic rw,
                                       input logic m2r, input logic mr, input logic mw,
                                       input logic src, input logic [1:0] aop,
                                       input logic done, input logic e, input logic [1:0] ec);
        return {pc, ir, rw, m2r, mr, mw, src, aop, done, e, ec};
    endfunction

    function automatic logic [12:0] outs();
        return {pc_write, ir_write, reg_write, mem_to_reg, mem_read, mem_write, alu_src,
                alu_op, instr_done, err, err_code};
    endfunction

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = outs();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check the current cycle's outputs, then advance one clock.
    task automatic step(input string tag, input logic [12:0] exp);
        #1;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    logic [12:0] z, f_rdy, f_wait, dec, addr_o;

    initial begin
        z      = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00);
        f_rdy  = ov(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00);
        f_wait = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00);
        dec    = z;
        addr_o = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00);

        rst = 1'b1; run = 1'b0; opcode = 4'd0; mem_ready = 1'b0;
        #12;
        chk("reset", z);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD then SUB back to back, zero memory wait
        mem_ready = 1'b1;
        step("idle_ready_ignored", z);
        run = 1'b1;
        step("idle_run", z);
        opcode = 4'b0001;
        step("add_fetch", f_rdy);
        step("add_decode", dec);
        step("add_exec", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00));
        step("add_wb", ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00));
        opcode = 4'b0010;
        step("sub_fetch", f_rdy);
        step("sub_decode", dec);
        opcode = 4'b0000;
        step("sub_exec", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'b00));
        step("sub_wb", ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 2'b00));

        // OR, then LOAD with three MEM wait cycles
        opcode = 4'b0100;
        step("or_fetch", f_rdy);
        step("or_decode", dec);
        step("or_exec", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 2'b00));
        step("or_wb", ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 2'b00));
        opcode = 4'b0101;
        step("ld_fetch", f_rdy);
        step("ld_decode", dec);
        mem_ready = 1'b0;
        step("ld_addr", addr_o);
        for (int i = 0; i < 3; i++)
            step("ld_mem_wait", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00));
        mem_ready = 1'b1;
        step("ld_mem_ready", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00));
        step("ld_wb", ov(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00));

        // STORE, run dropped mid-instruction: completes then IDLE
        opcode = 4'b0110;
        step("st_fetch", f_rdy);
        run = 1'b0;
        step("st_decode", dec);
        step("st_addr", addr_o);
        step("st_mem", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'b00));
        step("st_idle", z);

        // NOP: done in DECODE, run=0 returns to IDLE
        run = 1'b1; opcode = 4'b0000;
        step("nop_idle", z);
        run = 1'b0;
        step("nop_fetch", f_rdy);
        step("nop_decode", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00));
        step("nop_idle_after", z);

        // Illegal opcode 1001
        run = 1'b1; opcode = 4'b1001;
        step("ill_idle", z);
        step("ill_fetch", f_rdy);
        step("ill_decode", dec);
        mem_ready = 1'b0;
        step("ill_err_hold1", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01));
        mem_ready = 1'b1;
        step("ill_err_hold2", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01));
        run = 1'b0;
        step("ill_err_exit", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01));
        step("ill_idle_clear", z);

        // FETCH timeout: 17th stalled cycle goes to ERROR
        run = 1'b1; mem_ready = 1'b0;
        step("to_idle", z);
        for (int i = 0; i < 16; i++)
            step("to_fetch_wait", f_wait);
        #1; @(posedge clk); #1;
        step("to_error", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b10));
        run = 1'b0;
        step("to_error_exit", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b10));
        step("to_idle_clear", z);

        // mem_ready on the 17th cycle wins over the timeout
        run = 1'b1;
        step("tw_idle", z);
        for (int i = 0; i < 16; i++)
            step("tw_fetch_wait", f_wait);
        mem_ready = 1'b1; opcode = 4'b0000; run = 1'b0;
        step("tw_fetch_ready", f_rdy);
        step("tw_decode_nop", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00));
        step("tw_idle_after", z);

        // Asynchronous reset mid-LOAD in MEM
        run = 1'b1; opcode = 4'b0101;
        step("rl_idle", z);
        step("rl_fetch", f_rdy);
        step("rl_decode", dec);
        mem_ready = 1'b0;
        step("rl_addr", addr_o);
        #1;
        chk("rl_mem", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00));
        #1; rst = 1'b1;
        #1;
        chk("rl_async_reset", z);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("rl_restart_fetch", f_rdy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
